// File: rtl/fp_mult_hs.sv
// Parametrised floating-point multiplier with valid/ready handshake on both sides.
// Optional directed rounding modes are enabled by defining FPMUL_RND_MODE_EN.
module fp_mult_hs #(
    parameter  int EXP_W  = 8,
    parameter  int FRAC_W = 23,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst,
`ifdef FPMUL_RND_MODE_EN
    input  logic [1:0]   rnd_mode,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         invalid,
    output logic         overflow,
    output logic         underflow,
    output logic         inexact
);

    localparam int MW     = FRAC_W + 1;
    localparam int PW     = 2 * MW;
    localparam int EW     = EXP_W + 2;
    localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX_I = (1 << EXP_W) - 1;
    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX_I);
    localparam logic signed [EW-1:0] EZERO  = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASS,
        ST_MUL,
        ST_NORM,
        ST_RND,
        ST_OUT
    } state_t;

    state_t                r_state;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;
    logic [1:0]            r_rnd;
    logic                  r_sign;
    logic signed [EW-1:0]  r_exp;
    logic [PW-1:0]         r_prod;
    logic [MW-1:0]         r_mant;
    logic                  r_g;
    logic                  r_r;
    logic                  r_s;
    logic [W-1:0]          r_result;
    logic                  r_invalid;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_inexact;
    logic                  r_out_valid;

    // Operand classification
    logic [EXP_W-1:0]      w_ea;
    logic [EXP_W-1:0]      w_eb;
    logic [FRAC_W-1:0]     w_fa;
    logic [FRAC_W-1:0]     w_fb;
    logic                  w_a_zero;
    logic                  w_b_zero;
    logic                  w_a_inf;
    logic                  w_b_inf;
    logic                  w_a_nan;
    logic                  w_b_nan;
    logic                  w_sign;
    logic signed [EW-1:0]  w_exp_sum;
    logic [PW-1:0]         w_ma;
    logic [PW-1:0]         w_mb;

    assign w_ea      = r_a[W-2 -: EXP_W];
    assign w_eb      = r_b[W-2 -: EXP_W];
    assign w_fa      = r_a[FRAC_W-1:0];
    assign w_fb      = r_b[FRAC_W-1:0];
    assign w_a_zero  = (w_ea == '0);
    assign w_b_zero  = (w_eb == '0);
    assign w_a_inf   = (&w_ea) && (w_fa == '0);
    assign w_b_inf   = (&w_eb) && (w_fb == '0);
    assign w_a_nan   = (&w_ea) && (|w_fa);
    assign w_b_nan   = (&w_eb) && (|w_fb);
    assign w_sign    = r_a[W-1] ^ r_b[W-1];
    assign w_exp_sum = {2'b00, w_ea} + {2'b00, w_eb} - EW'(BIAS_I);
    assign w_ma      = {{MW{1'b0}}, 1'b1, w_fa};
    assign w_mb      = {{MW{1'b0}}, 1'b1, w_fb};

    // Normalisation of the raw product: top bit set means the product is in [2,4)
    logic                  w_msb;
    logic [MW-1:0]         w_norm_mant;
    logic                  w_norm_g;
    logic                  w_norm_r;
    logic                  w_norm_s;

    assign w_msb       = r_prod[PW-1];
    assign w_norm_mant = w_msb ? r_prod[PW-1 -: MW] : r_prod[PW-2 -: MW];
    assign w_norm_g    = w_msb ? r_prod[PW-MW-1]    : r_prod[PW-MW-2];
    assign w_norm_r    = w_msb ? r_prod[PW-MW-2]    : r_prod[PW-MW-3];
    assign w_norm_s    = w_msb ? (|r_prod[PW-MW-3:0]) : (|r_prod[PW-MW-4:0]);

    // Rounding
    logic                  w_any;
    logic                  w_up;
    logic                  w_ovf_to_max;
    logic [MW:0]           w_mant_inc;
    logic                  w_carry;
    logic [FRAC_W-1:0]     w_rnd_frac;
    logic signed [EW-1:0]  w_rnd_exp;
    logic                  w_ovf;
    logic                  w_unf;

    assign w_any = r_g | r_r | r_s;

`ifdef FPMUL_RND_MODE_EN
    always_comb begin
        w_up         = 1'b0;
        w_ovf_to_max = 1'b0;
        case (r_rnd)
            2'b00: w_up = r_g & (r_r | r_s | r_mant[0]);
            2'b01: begin
                w_up         = 1'b0;
                w_ovf_to_max = 1'b1;
            end
            2'b10: begin
                w_up         = w_any & ~r_sign;
                w_ovf_to_max = r_sign;
            end
            default: begin
                w_up         = w_any & r_sign;
                w_ovf_to_max = ~r_sign;
            end
        endcase
    end
`else
    assign w_up         = r_g & (r_r | r_s | r_mant[0]);
    assign w_ovf_to_max = 1'b0;
`endif

    assign w_mant_inc = {1'b0, r_mant} + {{MW{1'b0}}, w_up};
    assign w_carry    = w_mant_inc[MW];
    assign w_rnd_frac = w_carry ? w_mant_inc[FRAC_W:1] : w_mant_inc[FRAC_W-1:0];
    assign w_rnd_exp  = r_exp + {{(EW-1){1'b0}}, w_carry};
    assign w_ovf      = (w_rnd_exp >= EMAX_S);
    assign w_unf      = (w_rnd_exp <= EZERO);

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign invalid   = r_invalid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign inexact   = r_inexact;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rnd       <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_prod      <= '0;
            r_mant      <= '0;
            r_g         <= 1'b0;
            r_r         <= 1'b0;
            r_s         <= 1'b0;
            r_result    <= '0;
            r_invalid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
`ifdef FPMUL_RND_MODE_EN
                        r_rnd   <= rnd_mode;
`else
                        r_rnd   <= 2'b00;
`endif
                        r_state <= ST_CLASS;
                    end
                end
                ST_CLASS: begin
                    r_sign <= w_sign;
                    r_exp  <= w_exp_sum;
                    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
                        r_result    <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
                        r_invalid   <= 1'b1;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_inexact   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else if (w_a_inf || w_b_inf) begin
                        r_result    <= {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        r_invalid   <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_inexact   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else if (w_a_zero || w_b_zero) begin
                        r_result    <= {w_sign, {(W-1){1'b0}}};
                        r_invalid   <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_inexact   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else begin
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_prod  <= w_ma * w_mb;
                    r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_mant  <= w_norm_mant;
                    r_g     <= w_norm_g;
                    r_r     <= w_norm_r;
                    r_s     <= w_norm_s;
                    r_exp   <= r_exp + {{(EW-1){1'b0}}, w_msb};
                    r_state <= ST_RND;
                end
                ST_RND: begin
                    r_invalid <= 1'b0;
                    if (w_ovf) begin
                        // Directed modes that round away from infinity saturate instead
                        if (w_ovf_to_max)
                            r_result <= {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
                        else
                            r_result <= {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        r_overflow  <= 1'b1;
                        r_underflow <= 1'b0;
                        r_inexact   <= 1'b1;
                    end else if (w_unf) begin
                        r_result    <= {r_sign, {(W-1){1'b0}}};
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b1;
                        r_inexact   <= 1'b1;
                    end else begin
                        r_result    <= {r_sign, w_rnd_exp[EXP_W-1:0], w_rnd_frac};
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_inexact   <= w_any;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_hs.sv
// Scoreboard bench for fp_mult_hs: directed cases, backpressure, mid-op reset, random ops.
// Exercises the directed rounding case too when FPMUL_RND_MODE_EN is defined.
module tb_fp_mult_hs;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam int W = 1 + EXP_W + FRAC_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         invalid;
    logic         overflow;
    logic         underflow;
    logic         inexact;
`ifdef FPMUL_RND_MODE_EN
    logic [1:0]   rnd_mode;
`endif

    fp_mult_hs #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FPMUL_RND_MODE_EN
        .rnd_mode  (rnd_mode),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .invalid   (invalid),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   hold_ready = 1'b1;
    bit   ready_val = 1'b1;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: exact integer product, generic round on the remainder
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [1:0] rm, input int acc);
        exp_t   r;
        int     ex, ey, e, sh;
        longint fx, fy, m, q, rem, half;
        bit     s, xz, yz, xi, yi, xn, yn, up, to_max;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = longint'(x[22:0]);
        fy = longint'(y[22:0]);
        s  = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (fx == 0);
        yi = (ey == 255) && (fy == 0);
        xn = (ex == 255) && (fx != 0);
        yn = (ey == 255) && (fy != 0);
        r.acc = acc;
        r.lat = 1;
        r.flg = 4'b0000;
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            r.res = 32'h7FC0_0000;
            r.flg = 4'b1000;
        end else if (xi || yi) begin
            r.res = {s, 8'hFF, 23'h0};
        end else if (xz || yz) begin
            r.res = {s, 31'h0};
        end else begin
            r.lat = 4;
            m  = (fx + 64'd8388608) * (fy + 64'd8388608);
            e  = ex + ey - 127;
            sh = 23;
            if (m >= (64'd1 <<< 47)) begin
                sh = 24;
                e  = e + 1;
            end
            q    = m >>> sh;
            rem  = m - (q <<< sh);
            half = 64'd1 <<< (sh - 1);
            case (rm)
                2'd0:    up = (rem > half) || ((rem == half) && (q % 2 == 1));
                2'd1:    up = 1'b0;
                2'd2:    up = (rem != 0) && !s;
                default: up = (rem != 0) && s;
            endcase
            to_max = (rm == 2'd1) || ((rm == 2'd2) && s) || ((rm == 2'd3) && !s);
            if (up) q = q + 1;
            if (q == 64'd16777216) begin
                q = q >>> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                r.res = to_max ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
                r.flg = 4'b0101;
            end else if (e <= 0) begin
                r.res = {s, 31'h0};
                r.flg = 4'b0011;
            end else begin
                r.res = {s, 8'(e), 23'(q)};
                r.flg = {3'b000, rem != 0};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic [7:0]  e;
        logic [22:0] f;
        k = int'($urandom_range(0, 19));
        f = 23'($urandom);
        if (k == 5) f = '0;
        if (k == 6) f = 23'($urandom_range(0, 3));
        if (k == 7) f = 23'h400000;
        case (k)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; f = '0; end
            2:       begin e = 8'hFF; f = f | 23'h1; end
            3:       e = 8'($urandom_range(200, 254));
            4:       e = 8'($urandom_range(1, 60));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_ready ? ready_val : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        a = x;
        b = y;
        in_valid = 1'b1;
`ifdef FPMUL_RND_MODE_EN
        rnd_mode = rm;
`endif
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout got=in_ready_low want=in_ready_high");
                in_valid = 1'b0;
                return;
            end
        end
        sb_q.push_back(model(x, y, rm, cyc + 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
`ifdef FPMUL_RND_MODE_EN
        rnd_mode = 2'($urandom);
`endif
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=pending_%0d want=0", sb_q.size());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=%h want=no_output", result);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
                    end
                    chk("result", result, sb_q[0].res);
                    chk("flags", {28'h0, invalid, overflow, underflow, inexact},
                        {28'h0, sb_q[0].flg});
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
`ifdef FPMUL_RND_MODE_EN
        rnd_mode = 2'b00;
`endif
        #12;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {28'h0, invalid, overflow, underflow, inexact}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        send(32'h4040_0000, 32'h4020_0000, 2'b00);
        send(32'h7F80_0000, 32'h0000_0000, 2'b00);
        send(32'h7F00_0000, 32'h4000_0000, 2'b00);
        send(32'h3F80_0001, 32'h3F80_0001, 2'b00);
        send(32'h0080_0000, 32'h0080_0000, 2'b00);
        send(32'hBFC0_0000, 32'h7F80_0000, 2'b00);
        send(32'h8000_0000, 32'h4040_0000, 2'b00);
        send(32'h3FFF_FFFF, 32'h3FFF_FFFF, 2'b00);
`ifdef FPMUL_RND_MODE_EN
        send(32'h7F00_0000, 32'h4000_0000, 2'b01);
        send(32'hFF00_0000, 32'h4000_0000, 2'b10);
        send(32'h3F80_0001, 32'h3F80_0001, 2'b10);
`endif
        drain();

        // Backpressure: result held, new operands refused
        ready_val = 1'b0;
        send(32'h4040_0000, 32'h4020_0000, 2'b00);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ready_val = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid && n < 20);
        chk("bp_release_in_ready", {31'h0, in_ready}, 32'h1);
        drain();

        // Reset while the op sits in the multiply stage
        @(posedge clk);
        #1;
        a = 32'h4040_0000;
        b = 32'h4020_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send(32'h4040_0000, 32'h4020_0000, 2'b00);
        drain();

        hold_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
`ifdef FPMUL_RND_MODE_EN
            send(rand_op(), rand_op(), 2'($urandom));
`else
            send(rand_op(), rand_op(), 2'b00);
`endif
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
